softmax_frame_loader: RTL

Streaming front end for the softmax datapath. It accepts 16-bit elements one per cycle over a valid/ready handshake and assembles frames of `SIZE` elements. It optionally normalises each frame against its maximum, then presents the whole frame as a parallel vector (`x[1:SIZE]`) to the combinational softmax core. The vector and `out_valid` are held until the downstream side accepts them.

---
 rtl/softmax_pkg.sv | 17 +
 rtl/sat_sub.sv | 25 ++
 rtl/softmax_frame_loader.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/softmax_pkg.sv
// Shared definitions for the softmax front end: default sizes, loader FSM states
// and the most-negative element value used for padding and max reset.
package softmax_pkg;

  localparam int unsigned WID_DEFAULT  = 16;
  localparam int unsigned SIZE_DEFAULT = 5;

  // Most negative two's-complement element at the default width.
  localparam logic [WID_DEFAULT-1:0] ELEM_MIN = 16'h8000;

  typedef enum logic [1:0] {
    StCollect,
    StNorm,
    StHold
  } loader_state_t;

endpackage

// File: rtl/sat_sub.sv
// Combinational a - b on signed operands; the result is an unsigned WID-bit
// magnitude clamped to [0, 2^WID-1].
module sat_sub #(
  parameter int unsigned WID = 16
) (
  input  logic [WID-1:0] a_i,
  input  logic [WID-1:0] b_i,
  output logic [WID-1:0] y_o
);

  logic signed [WID+1:0] diff;

  // Two guard bits hold the full signed range of the difference.
  always_comb begin
    diff = $signed({{2{a_i[WID-1]}}, a_i}) - $signed({{2{b_i[WID-1]}}, b_i});
    if (diff < 0) begin
      y_o = '0;
    end else if (diff[WID+1:WID] != 2'b00) begin
      y_o = '1;
    end else begin
      y_o = diff[WID-1:0];
    end
  end

endmodule

// File: rtl/softmax_frame_loader.sv
// Streaming frame loader for the softmax core. Collects SIZE elements over a
// valid/ready handshake, optionally rewrites each slot as (frame max - element)
// when SOFTMAX_MAX_NORM_EN is defined, then holds the frame until accepted.
module softmax_frame_loader
  import softmax_pkg::*;
#(
  parameter int unsigned SIZE = SIZE_DEFAULT,
  parameter int unsigned WID  = WID_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [WID-1:0] in_data,
  input  logic           in_last,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [WID-1:0] x [1:SIZE],
  output logic           frame_err,
  input  logic           err_clr
);

  localparam int unsigned     IdxW    = $clog2(SIZE + 1);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(SIZE - 1);
  localparam logic [WID-1:0]  PadVal  = (WID == WID_DEFAULT) ? WID'(ELEM_MIN)
                                                            : {1'b1, {(WID-1){1'b0}}};

  loader_state_t   state_q;
  logic [IdxW-1:0] idx_q;
  logic [WID-1:0]  slot_q [SIZE];
  logic            in_ready_q;
  logic            out_valid_q;
  logic            frame_err_q;

  logic xfer;
  logic is_last_slot;
  logic close;
  logic err_set;

  assign xfer         = in_valid && in_ready_q && (state_q == StCollect);
  assign is_last_slot = (idx_q == LastIdx);
  assign close        = xfer && (in_last || is_last_slot);
  // Error whenever in_last and the final slot disagree on where the frame ends.
  assign err_set      = xfer && (in_last != is_last_slot);

`ifdef SOFTMAX_MAX_NORM_EN
  logic [WID-1:0] max_q;
  logic [WID-1:0] sub_y;

  // idx_q doubles as the NORM slot pointer, so one subtractor serves all slots.
  sat_sub #(
    .WID(WID)
  ) u_sat_sub (
    .a_i(max_q),
    .b_i(slot_q[idx_q]),
    .y_o(sub_y)
  );
`endif

  // Loader FSM, slot buffer, index counter and sticky error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StCollect;
      idx_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      for (int i = 0; i < SIZE; i++) begin
        slot_q[i] <= '0;
      end
`ifdef SOFTMAX_MAX_NORM_EN
      max_q <= PadVal;
`endif
    end else begin
      if (err_clr) begin
        frame_err_q <= 1'b0;
      end else if (err_set) begin
        frame_err_q <= 1'b1;
      end

      unique case (state_q)
        StCollect: begin
          in_ready_q <= 1'b1;
          if (xfer) begin
            slot_q[idx_q] <= in_data;
            idx_q         <= idx_q + IdxW'(1);
`ifdef SOFTMAX_MAX_NORM_EN
            if ($signed(in_data) > $signed(max_q)) begin
              max_q <= in_data;
            end
`endif
            if (close) begin
              in_ready_q <= 1'b0;
              // Short frame: pad the unfilled tail with the most negative value.
              for (int i = 0; i < SIZE; i++) begin
                if (in_last && (i > int'(idx_q))) begin
                  slot_q[i] <= PadVal;
                end
              end
`ifdef SOFTMAX_MAX_NORM_EN
              state_q <= StNorm;
              idx_q   <= '0;
`else
              state_q <= StHold;
`endif
            end
          end
        end

        StHold: begin
          // First HOLD cycle raises out_valid; accept is only seen once it is up.
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            idx_q       <= '0;
            state_q     <= StCollect;
`ifdef SOFTMAX_MAX_NORM_EN
            max_q       <= PadVal;
`endif
          end
        end

`ifdef SOFTMAX_MAX_NORM_EN
        StNorm: begin
          slot_q[idx_q] <= sub_y;
          idx_q         <= idx_q + IdxW'(1);
          if (is_last_slot) begin
            state_q <= StHold;
          end
        end
`endif

        default: begin
          state_q    <= StCollect;
          in_ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign frame_err = frame_err_q;

  for (genvar i = 1; i <= SIZE; i++) begin : g_x
    assign x[i] = slot_q[i-1];
  end

endmodule
